// File: rtl/pipeline_sequencer.sv
// Pipeline hazard/advance controller: stalls, flushes and halt draining for a NUM_STAGES-latch pipeline.
// Optional performance counters are enabled by defining PIPE_PERF_COUNTERS_EN.
//
// state  | meaning
// RUN    | normal issue; hazards resolved per cycle
// DRAIN  | HALT decoded; fetch stopped, bubbles fed in until the pipe empties
// HALTED | everything frozen until RST
module pipeline_sequencer #(
   parameter int NUM_STAGES = 5,
   parameter int REG_W      = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ihit,
   input  logic                  dhit,
   input  logic                  mem_req,
   input  logic [REG_W-1:0]      id_rs,
   input  logic [REG_W-1:0]      id_rt,
   input  logic                  ex_load,
   input  logic [REG_W-1:0]      ex_wsel,
   input  logic                  redirect,
   input  logic                  halt_in,
   output logic                  pc_en,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic [NUM_STAGES-1:0] stage_flush,
   output logic [NUM_STAGES-1:0] valid,
   output logic [1:0]            state,
   output logic                  halt,
   output logic [CNT_W-1:0]      cycle_cnt,
   output logic [CNT_W-1:0]      retire_cnt,
   output logic [CNT_W-1:0]      stall_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam int             DW         = 3;
   localparam logic [DW-1:0]  DRAIN_LOAD = DW'(NUM_STAGES - 1);

   state_t                cur_state;
   state_t                nxt_state;
   logic [DW-1:0]         drain_cnt;
   logic                  memstall;
   logic                  redir;
   logic                  loaduse;
   logic                  go_drain;
   logic [NUM_STAGES-1:0] valid_shift;

   assign memstall = valid[2] & mem_req & ~dhit;
   assign redir    = valid[1] & redirect;
   assign loaduse  = valid[1] & valid[0] & ex_load & (ex_wsel != '0) &
                     ((ex_wsel == id_rs) | (ex_wsel == id_rt));
   assign go_drain = halt_in & valid[0] & ~redir & ~memstall & ~loaduse;

   assign state = cur_state;
   assign halt  = (cur_state == HALTED);

   always_ff @(posedge CLK) begin
      if (RST) begin
         cur_state <= RUN;
         drain_cnt <= '0;
      end else begin
         cur_state <= nxt_state;
         if (cur_state == RUN && go_drain)
            drain_cnt <= DRAIN_LOAD;
         else if (cur_state == DRAIN && !memstall && drain_cnt != '0)
            drain_cnt <= drain_cnt - DW'(1);
      end
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         RUN:     if (go_drain) nxt_state = DRAIN;
         DRAIN:   if (!memstall && drain_cnt == DW'(1)) nxt_state = HALTED;
         HALTED:  nxt_state = HALTED;
         default: nxt_state = RUN;
      endcase
   end

   // Priority: reset > halted > memstall > redirect > load-use > fetch miss.
   always_comb begin
      pc_en       = 1'b0;
      stage_en    = '0;
      stage_flush = '0;
      if (RST) begin
         stage_flush = '1;
      end else if (cur_state == HALTED || memstall) begin
         pc_en = 1'b0;
      end else if (redir) begin
         pc_en            = 1'b1;
         stage_en         = '1;
         stage_flush[1:0] = 2'b11;
      end else if (loaduse) begin
         stage_en       = '1;
         stage_en[0]    = 1'b0;
         stage_flush[1] = 1'b1;
      end else if (!ihit && cur_state == RUN) begin
         stage_en       = '1;
         stage_flush[0] = 1'b1;
      end else begin
         pc_en    = 1'b1;
         stage_en = '1;
      end
      if (!RST && cur_state == DRAIN) begin
         pc_en          = 1'b0;
         stage_flush[0] = 1'b1;
      end
   end

   assign valid_shift = {valid[NUM_STAGES-2:0], 1'b1};

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid <= '0;
      end else begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_en[i])
               valid[i] <= stage_flush[i] ? 1'b0 : valid_shift[i];
         end
      end
   end

`ifdef PIPE_PERF_COUNTERS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (cur_state != HALTED)
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (valid[NUM_STAGES-1] && stage_en[NUM_STAGES-1])
            retire_cnt <= retire_cnt + CNT_W'(1);
         if (!pc_en && cur_state == RUN)
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`else
   assign cycle_cnt  = '0;
   assign retire_cnt = '0;
   assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer (NUM_STAGES=5, CNT_W=4): hazard vector table plus
// hand-written fill, memstall, drain/halt and counter sequences.
module tb_pipeline_sequencer;

   logic       CLK, RST, ihit, dhit, mem_req, ex_load, redirect, halt_in;
   logic [4:0] id_rs, id_rt, ex_wsel;
   logic       pc_en, halt;
   logic [4:0] stage_en, stage_flush, valid;
   logic [1:0] state;
   logic [3:0] cycle_cnt, retire_cnt, stall_cnt;

   int tests = 0;
   int fails = 0;

   pipeline_sequencer #(.NUM_STAGES(5), .REG_W(5), .CNT_W(4)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
      .id_rs(id_rs), .id_rt(id_rt), .ex_load(ex_load), .ex_wsel(ex_wsel),
      .redirect(redirect), .halt_in(halt_in), .pc_en(pc_en), .stage_en(stage_en),
      .stage_flush(stage_flush), .valid(valid), .state(state), .halt(halt),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic       ihit, dhit, mem_req;
      logic [4:0] id_rs, id_rt;
      logic       ex_load;
      logic [4:0] ex_wsel;
      logic       redirect, halt_in;
      logic       pc_en;
      logic [4:0] en, fl, nvalid;
      logic [1:0] nstate;
   } vec_t;

   vec_t vecs[16];
   vec_t exp_q[$];

   function automatic vec_t mk(bit ih, bit dh, bit mr, logic [4:0] rs, logic [4:0] rt, bit ld,
                               logic [4:0] ws, bit rd, bit hi, bit pc, logic [4:0] en,
                               logic [4:0] fl, logic [4:0] nv, logic [1:0] ns);
      vec_t v;
      v.ihit = ih; v.dhit = dh; v.mem_req = mr; v.id_rs = rs; v.id_rt = rt;
      v.ex_load = ld; v.ex_wsel = ws; v.redirect = rd; v.halt_in = hi;
      v.pc_en = pc; v.en = en; v.fl = fl; v.nvalid = nv; v.nstate = ns;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      ihit = 1'b1; dhit = 1'b1; mem_req = 1'b0; ex_load = 1'b0; redirect = 1'b0;
      halt_in = 1'b0; id_rs = 5'd1; id_rt = 5'd2; ex_wsel = 5'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RST = 1'b1;
      #1;
      chk("rst_pc_en", {31'b0, pc_en}, 32'd0);
      chk("rst_stage_en", {27'b0, stage_en}, 32'd0);
      chk("rst_stage_flush", {27'b0, stage_flush}, 32'h1f);
      tick();
      chk("rst_valid", {27'b0, valid}, 32'd0);
      chk("rst_state", {30'b0, state}, 32'd0);
      chk("rst_halt", {31'b0, halt}, 32'd0);
      chk("rst_cycle_cnt", {28'b0, cycle_cnt}, 32'd0);
      chk("rst_retire_cnt", {28'b0, retire_cnt}, 32'd0);
      chk("rst_stall_cnt", {28'b0, stall_cnt}, 32'd0);
      RST = 1'b0;
   endtask

   task automatic fill(input int n);
      idle_inputs();
      for (int k = 0; k < n; k++) tick();
   endtask

   // drain check: enter DRAIN from a full pipe, optionally stall stage 2 for a few cycles first
   task automatic drain_run(input int stalls);
      do_reset();
      fill(5);
      halt_in = 1'b1;
      tick();
      halt_in = 1'b0;
      chk("drain_enter_state", {30'b0, state}, 32'd1);
      chk("drain_pc_en", {31'b0, pc_en}, 32'd0);
      chk("drain_flush0", {31'b0, stage_flush[0]}, 32'd1);
      mem_req = 1'b1; dhit = 1'b0;
      for (int k = 0; k < stalls; k++) begin
         tick();
         chk("drain_stall_state", {30'b0, state}, 32'd1);
      end
      mem_req = 1'b0; dhit = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("drain_mid_state", {30'b0, state}, 32'd1);
         chk("drain_mid_halt", {31'b0, halt}, 32'd0);
      end
      tick();
      chk("halted_state", {30'b0, state}, 32'd2);
      chk("halted_halt", {31'b0, halt}, 32'd1);
      chk("halted_pc_en", {31'b0, pc_en}, 32'd0);
      chk("halted_stage_en", {27'b0, stage_en}, 32'd0);
   endtask

   initial begin
      vec_t e;
      logic [31:0] exp_cyc, exp_ret, exp_stl;
      RST = 1'b1;
      idle_inputs();

      vecs[0]  = mk(1,1,0,1,2,0,0,0,0, 1,5'h1f,5'h00,5'h1f,0);
      vecs[1]  = mk(0,1,0,1,2,0,0,0,0, 0,5'h1f,5'h01,5'h1e,0);
      vecs[2]  = mk(1,1,0,3,8,1,8,0,0, 0,5'h1e,5'h02,5'h1d,0);
      vecs[3]  = mk(1,1,0,8,3,1,8,0,0, 0,5'h1e,5'h02,5'h1d,0);
      vecs[4]  = mk(1,1,0,0,0,1,0,0,0, 1,5'h1f,5'h00,5'h1f,0);
      vecs[5]  = mk(1,1,0,8,8,0,8,0,0, 1,5'h1f,5'h00,5'h1f,0);
      vecs[6]  = mk(1,1,0,1,2,0,0,1,0, 1,5'h1f,5'h03,5'h1c,0);
      vecs[7]  = mk(1,0,1,1,2,0,0,0,0, 0,5'h00,5'h00,5'h1f,0);
      vecs[8]  = mk(1,1,1,1,2,0,0,0,0, 1,5'h1f,5'h00,5'h1f,0);
      vecs[9]  = mk(1,0,1,8,8,1,8,1,0, 0,5'h00,5'h00,5'h1f,0);
      vecs[10] = mk(1,1,0,8,8,1,8,1,0, 1,5'h1f,5'h03,5'h1c,0);
      vecs[11] = mk(1,1,0,1,2,0,0,1,1, 1,5'h1f,5'h03,5'h1c,0);
      vecs[12] = mk(0,1,0,8,2,1,8,0,1, 0,5'h1e,5'h02,5'h1d,0);
      vecs[13] = mk(1,1,0,1,2,0,0,0,1, 1,5'h1f,5'h00,5'h1f,1);
      vecs[14] = mk(1,0,1,1,2,0,0,0,1, 0,5'h00,5'h00,5'h1f,0);
      vecs[15] = mk(0,1,0,1,2,0,0,0,1, 0,5'h1f,5'h01,5'h1e,1);

      // fill sequence and counters: 17 RUN cycles after reset
      do_reset();
      idle_inputs();
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk($sformatf("fill_valid_%0d", k), {27'b0, valid}, (32'd1 << k) - 32'd1);
      end
      for (int k = 6; k <= 17; k++) tick();
`ifdef PIPE_PERF_COUNTERS_EN
      exp_cyc = 32'd1; exp_ret = 32'd12; exp_stl = 32'd0;
`else
      exp_cyc = 32'd0; exp_ret = 32'd0; exp_stl = 32'd0;
`endif
      chk("cnt17_cycle", {28'b0, cycle_cnt}, exp_cyc);
      chk("cnt17_retire", {28'b0, retire_cnt}, exp_ret);
      chk("cnt17_stall", {28'b0, stall_cnt}, exp_stl);

      // hazard vector table, each from a full pipe
      for (int i = 0; i < 16; i++) begin
         do_reset();
         fill(5);
         ihit = vecs[i].ihit; dhit = vecs[i].dhit; mem_req = vecs[i].mem_req;
         id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt; ex_load = vecs[i].ex_load;
         ex_wsel = vecs[i].ex_wsel; redirect = vecs[i].redirect; halt_in = vecs[i].halt_in;
         exp_q.push_back(vecs[i]);
         #1;
         e = exp_q.pop_front();
         chk($sformatf("vec%0d_pc_en", i), {31'b0, pc_en}, {31'b0, e.pc_en});
         chk($sformatf("vec%0d_stage_en", i), {27'b0, stage_en}, {27'b0, e.en});
         chk($sformatf("vec%0d_stage_flush", i), {27'b0, stage_flush}, {27'b0, e.fl});
         @(posedge CLK);
         #1;
         chk($sformatf("vec%0d_next_valid", i), {27'b0, valid}, {27'b0, e.nvalid});
         chk($sformatf("vec%0d_next_state", i), {30'b0, state}, {30'b0, e.nstate});
      end

      // memstall held 3 cycles on a partly filled pipe, then released
      do_reset();
      fill(3);
      chk("ms_pre_valid", {27'b0, valid}, 32'h07);
      mem_req = 1'b1; dhit = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("ms_stage_en", {27'b0, stage_en}, 32'd0);
         chk("ms_pc_en", {31'b0, pc_en}, 32'd0);
         @(posedge CLK);
         #1;
         chk("ms_valid_hold", {27'b0, valid}, 32'h07);
      end
`ifdef PIPE_PERF_COUNTERS_EN
      exp_stl = 32'd3;
`else
      exp_stl = 32'd0;
`endif
      chk("ms_stall_cnt", {28'b0, stall_cnt}, exp_stl);
      dhit = 1'b1;
      #1;
      chk("ms_release_stage_en", {27'b0, stage_en}, 32'h1f);
      tick();
      chk("ms_release_valid", {27'b0, valid}, 32'h0f);

      // halt drain without stalls, HALTED holds, then reset out of HALTED
      drain_run(0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("halted_hold_state", {30'b0, state}, 32'd2);
      end
`ifdef PIPE_PERF_COUNTERS_EN
      exp_cyc = 32'd10;
`else
      exp_cyc = 32'd0;
`endif
      chk("halted_cycle_frozen", {28'b0, cycle_cnt}, exp_cyc);
      do_reset();

      // drain with stage-2 stalls: countdown pauses
      drain_run(2);
      do_reset();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
